// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with a valid/ready load
// port, per-bit stall and zero-gap back-to-back frames.
module piso_serializer #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_valid_i,
   output logic             load_ready_o,
   input  logic [WIDTH-1:0] par_in_i,
   input  logic             shift_en_i,
   output logic             serial_out_o,
   output logic             serial_valid_o,
   output logic             done_o
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;

   logic             in_shift;
   logic             last_bit;
   logic             accept;
   logic [WIDTH-1:0] sreg_shifted;

   assign in_shift = (state_q == SHIFT);

   // last_bit: final bit of the frame leaves on this edge
   assign last_bit = in_shift && (cnt_q == LAST) && shift_en_i;

   assign load_ready_o   = !in_shift || last_bit;
   assign accept         = load_valid_i && load_ready_o;
   assign serial_valid_o = in_shift;
   assign done_o         = done_q;

   always_comb begin
      if (MSB_FIRST) begin
         sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
         serial_out_o = in_shift && sreg_q[WIDTH-1];
      end else begin
         sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
         serial_out_o = in_shift && sreg_q[0];
      end
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
         end
         SHIFT: begin
            if (shift_en_i) begin
               sreg_d = sreg_shifted;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // a new word overrides the drain to IDLE for zero-gap frames
      if (accept) begin
         state_d = SHIFT;
         sreg_d  = par_in_i;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

endmodule
